// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_SRC byte producers onto the single UART TX FIFO write port,
// one registered write strobe per grant followed by a settle cycle and optional gap.
//
// state  | meaning
// IDLE   | waiting for a valid source while the FIFO is not full
// WRITE  | strobe and ack visible for exactly one cycle
// SETTLE | one dead cycle so the acked source can drop or refresh valid
// GAP    | WRITE_GAP extra idle cycles, counted down to zero
module uart_tx_arbiter #(
    parameter int NUM_SRC       = 3,
    parameter int WRITE_GAP     = 0,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [8*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]     src_ack,
    input  logic                   tx_fifo_full,
    output logic                   tx_fifo_write_en,
    output logic [7:0]             tx_fifo_data_in,
    output logic [2:0]             grant_id,
    output logic                   busy
);

    localparam int         IW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [3:0] NSRC4    = 4'(NUM_SRC);
    localparam logic [7:0] GAP_LOAD = 8'((WRITE_GAP > 0) ? WRITE_GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, WRITE, SETTLE, GAP} state_t;

    state_t               state, state_nx;
    logic [2:0]           last, last_nx;
    logic [7:0]           gap_cnt, gap_nx;
    logic [NUM_SRC-1:0]   ack_nx;
    logic                 we_nx;
    logic [7:0]           data_nx;
    logic [2:0]           gid_nx;

    logic                 found;
    logic [2:0]           win;
    logic [7:0]           win_lane;
    logic [3:0]           rr_sum;
    logic [IW-1:0]        rr_idx;

    // Searches descend so the highest-priority candidate is the last one written.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_lane = '0;
        rr_sum   = '0;
        rr_idx   = '0;
        if (PRIORITY_MODE != 0) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (src_valid[IW'(i)]) begin
                    found = 1'b1;
                    win   = 3'(i);
                end
            end
        end else begin
            for (int k = NUM_SRC; k >= 1; k--) begin
                rr_sum = {1'b0, last} + 4'(k);
                rr_idx = IW'((rr_sum >= NSRC4) ? rr_sum - NSRC4 : rr_sum);
                if (src_valid[rr_idx]) begin
                    found = 1'b1;
                    win   = 3'(rr_idx);
                end
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win == 3'(i)) begin
                win_lane = src_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        last_nx  = last;
        ack_nx   = '0;
        we_nx    = 1'b0;
        data_nx  = tx_fifo_data_in;
        gid_nx   = grant_id;
        case (state)
            IDLE: begin
                if (found && !tx_fifo_full) begin
                    ack_nx   = NUM_SRC'(1) << win;
                    we_nx    = 1'b1;
                    data_nx  = win_lane;
                    gid_nx   = win;
                    last_nx  = win;
                    state_nx = WRITE;
                end
            end
            WRITE: state_nx = SETTLE;
            SETTLE: begin
                if (WRITE_GAP == 0) begin
                    state_nx = IDLE;
                end else begin
                    gap_nx   = GAP_LOAD;
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) state_nx = IDLE;
                else                 gap_nx   = gap_cnt - 8'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            gap_cnt          <= '0;
            last             <= 3'(NUM_SRC - 1);
            src_ack          <= '0;
            tx_fifo_write_en <= 1'b0;
            tx_fifo_data_in  <= '0;
            grant_id         <= '0;
        end else begin
            state            <= state_nx;
            gap_cnt          <= gap_nx;
            last             <= last_nx;
            src_ack          <= ack_nx;
            tx_fifo_write_en <= we_nx;
            tx_fifo_data_in  <= data_nx;
            grant_id         <= gid_nx;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a round-robin/no-gap instance and a fixed-priority/gap-4
// instance share one stimulus and are each compared cycle by cycle against a grant model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  v;
    logic [7:0]  lane [3];
    logic [23:0] src_data;
    logic        full;

    logic [2:0]  ack0, ack1;
    logic        we0, we1, busy0, busy1;
    logic [7:0]  data0, data1;
    logic [2:0]  gid0, gid1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cool;
        int         last;
        logic       we;
        logic [2:0] ack;
        logic [7:0] data;
        logic [2:0] gid;
    } model_t;

    model_t m0, m1;

    assign src_data = {lane[2], lane[1], lane[0]};

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_SRC(3), .WRITE_GAP(0), .PRIORITY_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .src_valid(v), .src_data(src_data), .src_ack(ack0),
        .tx_fifo_full(full), .tx_fifo_write_en(we0), .tx_fifo_data_in(data0),
        .grant_id(gid0), .busy(busy0));

    uart_tx_arbiter #(.NUM_SRC(3), .WRITE_GAP(4), .PRIORITY_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .src_valid(v), .src_data(src_data), .src_ack(ack1),
        .tx_fifo_full(full), .tx_fifo_write_en(we1), .tx_fifo_data_in(data1),
        .grant_id(gid1), .busy(busy1));

    // cool = cycles the arbiter stays busy after a grant edge (strobe + settle + gap).
    function automatic model_t model_next(model_t m, int mode, int gap, logic rst,
                                          logic [2:0] vv, logic [7:0] l0, logic [7:0] l1,
                                          logic [7:0] l2, logic f);
        model_t n;
        int w;
        logic [7:0] l [3];
        l[0] = l0; l[1] = l1; l[2] = l2;
        n = m;
        n.we  = 1'b0;
        n.ack = 3'b000;
        if (rst) begin
            n.cool = 0; n.last = 2; n.data = 8'h00; n.gid = 3'd0;
            return n;
        end
        if (m.cool > 0) begin
            n.cool = m.cool - 1;
        end else if (vv != 3'b000 && !f) begin
            if (mode == 1) begin
                w = 0;
                while (!vv[w]) w++;
            end else begin
                w = m.last;
                do w = (w + 1) % 3; while (!vv[w]);
            end
            n.we   = 1'b1;
            n.ack  = 3'(1 << w);
            n.data = l[w];
            n.gid  = 3'(w);
            n.last = w;
            n.cool = 2 + gap;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m0 = model_next(m0, 0, 0, reset, v, lane[0], lane[1], lane[2], full);
        m1 = model_next(m1, 1, 4, reset, v, lane[0], lane[1], lane[2], full);
        #1;
        chk("rr_we",    32'(we0),   32'(m0.we));
        chk("rr_ack",   32'(ack0),  32'(m0.ack));
        chk("rr_data",  32'(data0), 32'(m0.data));
        chk("rr_gid",   32'(gid0),  32'(m0.gid));
        chk("rr_busy",  32'(busy0), 32'(m0.cool > 0));
        chk("rr_onehot", 32'($countones(ack0) <= 1), 32'd1);
        chk("fp_we",    32'(we1),   32'(m1.we));
        chk("fp_ack",   32'(ack1),  32'(m1.ack));
        chk("fp_data",  32'(data1), 32'(m1.data));
        chk("fp_gid",   32'(gid1),  32'(m1.gid));
        chk("fp_busy",  32'(busy1), 32'(m1.cool > 0));
        chk("fp_ack_we", 32'(ack1 != 3'b000), 32'(we1));
    endtask

    initial begin
        logic [7:0] got [$];
        int         tim [$];
        int         cyc, nfp, bcnt;
        logic       hit;
        logic [7:0] rr_exp [3];

        reset = 1'b1; v = 3'b000; full = 1'b0;
        lane[0] = 8'h00; lane[1] = 8'h00; lane[2] = 8'h00;
        tick(); tick();
        chk("reset_we",   32'(we0),   32'd0);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_gid",  32'(gid0),  32'd0);
        chk("reset_data", 32'(data0), 32'd0);

        // Single request: strobe one cycle later, next grant three cycles after that.
        reset = 1'b0; v = 3'b001; lane[0] = 8'h41;
        tick();
        chk("single_we",   32'(we0),   32'd1);
        chk("single_ack",  32'(ack0),  32'b001);
        chk("single_data", 32'(data0), 32'h41);
        chk("single_gid",  32'(gid0),  32'd0);
        lane[0] = 8'h42;
        tick(); chk("single_settle_we", 32'(we0), 32'd0);
        tick(); chk("single_idle_we",   32'(we0), 32'd0);
        tick();
        chk("single_next_we",   32'(we0),   32'd1);
        chk("single_next_data", 32'(data0), 32'h42);

        // Round-robin contention from reset.
        reset = 1'b1; v = 3'b000; tick();
        reset = 1'b0; v = 3'b111;
        lane[0] = 8'h10; lane[1] = 8'h20; lane[2] = 8'h30;
        rr_exp[0] = 8'h10; rr_exp[1] = 8'h20; rr_exp[2] = 8'h30;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (we0) begin got.push_back(data0); tim.push_back(i); end
        end
        chk("rr_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < got.size(); i++) begin
            chk("rr_order", 32'(got[i]), 32'(rr_exp[i % 3]));
            if (i > 0) chk("rr_spacing", 32'(tim[i] - tim[i-1]), 32'd3);
        end

        // Fixed priority: source 0 starves source 2 until it drops.
        v = 3'b101; nfp = 0;
        for (int i = 0; i < 21; i++) begin
            tick();
            if (we1) begin nfp++; chk("fp_starve_gid", 32'(gid1), 32'd0); end
        end
        chk("fp_starve_count", 32'(nfp >= 2), 32'd1);
        v = 3'b100; hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick();
            if (we1) hit = 1'b1;
        end
        chk("fp_src2_granted", 32'(hit), 32'd1);
        chk("fp_src2_gid", 32'(gid1), 32'd2);

        // FIFO full back-pressure.
        v = 3'b000;
        for (int i = 0; i < 8; i++) tick();
        full = 1'b1; v = 3'b010; lane[1] = 8'h55;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("full_we",   32'(we0),   32'd0);
            chk("full_ack",  32'(ack0),  32'd0);
            chk("full_busy", 32'(busy0), 32'd0);
        end
        full = 1'b0;
        tick();
        chk("full_release_we",   32'(we0),   32'd1);
        chk("full_release_data", 32'(data0), 32'h55);
        chk("full_release_gid",  32'(gid0),  32'd1);

        // Gap timing on the WRITE_GAP=4 instance.
        v = 3'b001; lane[0] = 8'h77; hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick();
            if (we1 && gid1 == 3'd0) hit = 1'b1;
        end
        chk("gap_first_strobe", 32'(hit), 32'd1);
        bcnt = busy1 ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("gap_no_strobe", 32'(we1), 32'd0);
            if (busy1) bcnt++;
        end
        tick();
        chk("gap_strobe_7", 32'(we1), 32'd1);
        chk("gap_busy_6of7", 32'(bcnt), 32'd6);

        // Reset during the WRITE cycle of a grant to source 2.
        v = 3'b100; hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick();
            if (we0 && gid0 == 3'd2) hit = 1'b1;
        end
        chk("mid_reset_grant2", 32'(hit), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_reset_we",   32'(we0),   32'd0);
        chk("mid_reset_ack",  32'(ack0),  32'd0);
        chk("mid_reset_busy", 32'(busy0), 32'd0);
        chk("mid_reset_gid",  32'(gid0),  32'd0);
        reset = 1'b0; v = 3'b111;
        tick();
        chk("post_reset_we",  32'(we0),  32'd1);
        chk("post_reset_gid", 32'(gid0), 32'd0);

        // Randomized traffic against the model.
        cyc = 0;
        repeat (400) begin
            v       = 3'($urandom_range(0, 7));
            lane[0] = 8'($urandom);
            lane[1] = 8'($urandom);
            lane[2] = 8'($urandom);
            full    = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 63) == 0);
            tick();
            cyc++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
